// File: rtl/cnt_cam_scan.sv
// Per-row activation counter CAM with saturating counts and a lane-parallel sequential max scan.
// Optional CNT_CAM_CLR_ON_MAX_EN: the entry reported by a scan is invalidated when the result is published.

module cnt_cam_scan_lane #(
    parameter int TAG_W = 16,
    parameter int CNT_W = 16,
    parameter int IDX_W = 6
) (
    input  logic             in_found,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic             ent_vld,
    input  logic [IDX_W-1:0] ent_idx,
    input  logic [TAG_W-1:0] ent_tag,
    input  logic [CNT_W-1:0] ent_cnt,
    output logic             out_found,
    output logic [IDX_W-1:0] out_idx,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] out_cnt
);
    logic take;

    // Strict '>' keeps the earlier (lower-index) entry on ties.
    assign take      = ent_vld && (!in_found || (ent_cnt > in_cnt));
    assign out_found = in_found | ent_vld;
    assign out_idx   = take ? ent_idx : in_idx;
    assign out_tag   = take ? ent_tag : in_tag;
    assign out_cnt   = take ? ent_cnt : in_cnt;
endmodule

module cnt_cam_scan #(
    parameter int TAG_W      = 16,
    parameter int CNT_W      = 16,
    parameter int ENTRY_NUM  = 64,
    parameter int IDX_W      = 6,
    parameter int SCAN_LANES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             act_valid,
    input  logic [TAG_W-1:0] act_tag,
    output logic             act_ready,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic             resp_drop,
    output logic [IDX_W-1:0] resp_idx,
    output logic [CNT_W-1:0] resp_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    input  logic             max_req,
    output logic             max_busy,
    output logic             max_valid,
    output logic             max_found,
    output logic [IDX_W-1:0] max_idx,
    output logic [TAG_W-1:0] max_tag,
    output logic [CNT_W-1:0] max_cnt
);
    localparam int GRP_NUM = ENTRY_NUM / SCAN_LANES;
    localparam int GRP_W   = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [CNT_W-1:0] cnt;
    } best_t;

    typedef struct packed {
        logic             hit;
        logic             drop;
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] cnt;
    } resp_t;

    state_t state, state_nxt;
    logic [GRP_W-1:0] grp;

    logic [ENTRY_NUM-1:0]            ent_vld;
    logic [ENTRY_NUM-1:0][TAG_W-1:0] ent_tag;
    logic [ENTRY_NUM-1:0][CNT_W-1:0] ent_cnt;

    resp_t resp_q;
    best_t best_q, scan_best, max_q;

    // Lookup: tags are unique among valid entries, free slot is the lowest index.
    logic [ENTRY_NUM-1:0] hit_vec;
    logic                 hit, free;
    logic [IDX_W-1:0]     hit_idx, free_idx;
    logic [CNT_W-1:0]     hit_cnt;
    logic                 act_fire;

    for (genvar e = 0; e < ENTRY_NUM; e++) begin : g_match
        assign hit_vec[e] = ent_vld[e] && (ent_tag[e] == act_tag);
    end

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int e = ENTRY_NUM - 1; e >= 0; e--) begin
            if (hit_vec[e]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(e);
            end
            if (!ent_vld[e]) begin
                free     = 1'b1;
                free_idx = IDX_W'(e);
            end
        end
    end

    assign hit_cnt  = (ent_cnt[hit_idx] == CNT_MAX) ? CNT_MAX : ent_cnt[hit_idx] + 1'b1;
    assign act_ready = (state == IDLE);
    assign act_fire  = act_valid && act_ready;
    assign max_busy  = (state != IDLE);

    // Scan datapath: one compare-select lane per entry of the current group, chained.
    logic [SCAN_LANES:0]            ch_found;
    logic [SCAN_LANES:0][IDX_W-1:0] ch_idx;
    logic [SCAN_LANES:0][TAG_W-1:0] ch_tag;
    logic [SCAN_LANES:0][CNT_W-1:0] ch_cnt;
    logic [SCAN_LANES-1:0][IDX_W-1:0] lane_idx;

    assign ch_found[0] = best_q.found;
    assign ch_idx[0]   = best_q.idx;
    assign ch_tag[0]   = best_q.tag;
    assign ch_cnt[0]   = best_q.cnt;

    for (genvar l = 0; l < SCAN_LANES; l++) begin : g_lane
        assign lane_idx[l] = IDX_W'(32'(grp) * SCAN_LANES + l);
        cnt_cam_scan_lane #(.TAG_W(TAG_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_lane (
            .in_found  (ch_found[l]),
            .in_idx    (ch_idx[l]),
            .in_tag    (ch_tag[l]),
            .in_cnt    (ch_cnt[l]),
            .ent_vld   (ent_vld[lane_idx[l]]),
            .ent_idx   (lane_idx[l]),
            .ent_tag   (ent_tag[lane_idx[l]]),
            .ent_cnt   (ent_cnt[lane_idx[l]]),
            .out_found (ch_found[l+1]),
            .out_idx   (ch_idx[l+1]),
            .out_tag   (ch_tag[l+1]),
            .out_cnt   (ch_cnt[l+1])
        );
    end

    assign scan_best = '{ch_found[SCAN_LANES], ch_idx[SCAN_LANES],
                         ch_tag[SCAN_LANES], ch_cnt[SCAN_LANES]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (max_req) state_nxt = SCAN;
            SCAN:    if (grp == GRP_W'(GRP_NUM - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grp        <= '0;
            ent_vld    <= '0;
            ent_tag    <= '0;
            ent_cnt    <= '0;
            resp_valid <= 1'b0;
            resp_q     <= '0;
            drop_cnt   <= '0;
            best_q     <= '0;
            max_valid  <= 1'b0;
            max_q      <= '0;
        end else if (clr) begin
            // Tags, drop_cnt and the last published result survive a flush.
            state      <= IDLE;
            grp        <= '0;
            ent_vld    <= '0;
            ent_cnt    <= '0;
            resp_valid <= 1'b0;
            max_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            resp_valid <= act_fire;
            max_valid  <= 1'b0;
            if (act_fire) begin
                if (hit) begin
                    ent_cnt[hit_idx] <= hit_cnt;
                    resp_q <= '{1'b1, 1'b0, hit_idx, hit_cnt};
                end else if (free) begin
                    ent_vld[free_idx] <= 1'b1;
                    ent_tag[free_idx] <= act_tag;
                    ent_cnt[free_idx] <= CNT_W'(1);
                    resp_q <= '{1'b0, 1'b0, free_idx, CNT_W'(1)};
                end else begin
                    resp_q <= '{1'b0, 1'b1, {IDX_W{1'b0}}, {CNT_W{1'b0}}};
                    if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
                end
            end
            case (state)
                IDLE: if (max_req) begin
                    grp    <= '0;
                    best_q <= '0;
                end
                SCAN: begin
                    grp    <= grp + 1'b1;
                    best_q <= scan_best;
                end
                DONE: begin
                    max_valid <= 1'b1;
                    max_q     <= best_q;
`ifdef CNT_CAM_CLR_ON_MAX_EN
                    if (best_q.found) begin
                        ent_vld[best_q.idx] <= 1'b0;
                        ent_cnt[best_q.idx] <= '0;
                    end
`else
`endif
                end
                default: ;
            endcase
        end
    end

    assign resp_hit  = resp_q.hit;
    assign resp_drop = resp_q.drop;
    assign resp_idx  = resp_q.idx;
    assign resp_cnt  = resp_q.cnt;
    assign max_found = max_q.found;
    assign max_idx   = max_q.idx;
    assign max_tag   = max_q.tag;
    assign max_cnt   = max_q.cnt;
endmodule

// File: tb/tb_cnt_cam_scan.sv
// Scoreboard bench for cnt_cam_scan: a reference table model predicts every response and scan result.
// A second small instance exercises counter and drop saturation.

module tb_cnt_cam_scan;
    logic        clk = 1'b0;
    logic        reset, clr, act_valid, max_req;
    logic [15:0] act_tag;
    logic        act_ready, resp_valid, resp_hit, resp_drop, max_busy, max_valid, max_found;
    logic [5:0]  resp_idx, max_idx;
    logic [15:0] resp_cnt, drop_cnt, max_tag, max_cnt;

    logic        s_act_valid, s_max_req, s_clr;
    logic [7:0]  s_act_tag, s_max_tag;
    logic        s_act_ready, s_resp_valid, s_resp_hit, s_resp_drop, s_max_busy, s_max_valid, s_max_found;
    logic [2:0]  s_resp_idx, s_max_idx;
    logic [3:0]  s_resp_cnt, s_drop_cnt, s_max_cnt;

    int n_chk = 0, n_err = 0, cyc = 0;

    typedef struct {
        logic        hit;
        logic        drop;
        logic [5:0]  idx;
        logic [15:0] cnt;
    } exp_resp_t;

    typedef struct {
        logic        found;
        logic [5:0]  idx;
        logic [15:0] tag;
        logic [15:0] cnt;
        int          due;
    } exp_max_t;

    exp_resp_t q_resp[$];
    exp_max_t  q_max[$];
    exp_resp_t er;
    exp_max_t  em;

    logic        m_vld[64];
    logic [15:0] m_tag[64];
    logic [15:0] m_cnt[64];
    logic [15:0] m_drop;

    cnt_cam_scan dut (
        .clk(clk), .reset(reset), .clr(clr),
        .act_valid(act_valid), .act_tag(act_tag), .act_ready(act_ready),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_drop(resp_drop),
        .resp_idx(resp_idx), .resp_cnt(resp_cnt), .drop_cnt(drop_cnt),
        .max_req(max_req), .max_busy(max_busy), .max_valid(max_valid),
        .max_found(max_found), .max_idx(max_idx), .max_tag(max_tag), .max_cnt(max_cnt)
    );

    cnt_cam_scan #(.TAG_W(8), .CNT_W(4), .ENTRY_NUM(8), .IDX_W(3), .SCAN_LANES(2)) dut_s (
        .clk(clk), .reset(reset), .clr(s_clr),
        .act_valid(s_act_valid), .act_tag(s_act_tag), .act_ready(s_act_ready),
        .resp_valid(s_resp_valid), .resp_hit(s_resp_hit), .resp_drop(s_resp_drop),
        .resp_idx(s_resp_idx), .resp_cnt(s_resp_cnt), .drop_cnt(s_drop_cnt),
        .max_req(s_max_req), .max_busy(s_max_busy), .max_valid(s_max_valid),
        .max_found(s_max_found), .max_idx(s_max_idx), .max_tag(s_max_tag), .max_cnt(s_max_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_vld[i] = 1'b0;
            m_cnt[i] = 16'd0;
        end
    endtask

    task automatic model_act(input logic [15:0] tag, output exp_resp_t e);
        int h, f;
        h = -1;
        f = -1;
        for (int i = 0; i < 64; i++) begin
            if (h < 0 && m_vld[i] && m_tag[i] == tag) h = i;
            if (f < 0 && !m_vld[i]) f = i;
        end
        if (h >= 0) begin
            if (m_cnt[h] != 16'hFFFF) m_cnt[h] = m_cnt[h] + 16'd1;
            e = '{1'b1, 1'b0, 6'(h), m_cnt[h]};
        end else if (f >= 0) begin
            m_vld[f] = 1'b1;
            m_tag[f] = tag;
            m_cnt[f] = 16'd1;
            e = '{1'b0, 1'b0, 6'(f), 16'd1};
        end else begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            e = '{1'b0, 1'b1, 6'd0, 16'd0};
        end
    endtask

    // Called in the cycle max_req is driven; the result is due 17 cycles after it is sampled.
    task automatic push_scan();
        exp_max_t e;
        e = '{1'b0, 6'd0, 16'd0, 16'd0, cyc + 18};
        for (int i = 0; i < 64; i++) begin
            if (m_vld[i] && (!e.found || m_cnt[i] > e.cnt)) begin
                e.found = 1'b1;
                e.idx   = 6'(i);
                e.tag   = m_tag[i];
                e.cnt   = m_cnt[i];
            end
        end
`ifdef CNT_CAM_CLR_ON_MAX_EN
        if (e.found) begin
            m_vld[e.idx] = 1'b0;
            m_cnt[e.idx] = 16'd0;
        end
`endif
        q_max.push_back(e);
    endtask

    task automatic act(input logic [15:0] tag);
        exp_resp_t e;
        chk("act_ready", 32'(act_ready), 32'd1);
        model_act(tag, e);
        q_resp.push_back(e);
        act_valid = 1'b1;
        act_tag   = tag;
        step();
        act_valid = 1'b0;
    endtask

    task automatic scan();
        push_scan();
        max_req = 1'b1;
        step();
        max_req = 1'b0;
    endtask

    task automatic wait_scan();
        for (int i = 0; i < 40 && q_max.size() != 0; i++) step();
        chk("scan_timeout", 32'(q_max.size()), 32'd0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_clear();
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            chk("resp_pending", 32'(q_resp.size() > 0), 32'd1);
            if (q_resp.size() > 0) begin
                er = q_resp.pop_front();
                chk("resp_hit", 32'(resp_hit), 32'(er.hit));
                chk("resp_drop", 32'(resp_drop), 32'(er.drop));
                chk("resp_idx", 32'(resp_idx), 32'(er.idx));
                chk("resp_cnt", 32'(resp_cnt), 32'(er.cnt));
            end
        end
        if (max_valid) begin
            chk("max_pending", 32'(q_max.size() > 0), 32'd1);
            if (q_max.size() > 0) begin
                em = q_max.pop_front();
                chk("max_lat", 32'(cyc), 32'(em.due));
                chk("max_found", 32'(max_found), 32'(em.found));
                chk("max_idx", 32'(max_idx), 32'(em.idx));
                chk("max_tag", 32'(max_tag), 32'(em.tag));
                chk("max_cnt", 32'(max_cnt), 32'(em.cnt));
            end
        end
    end

    initial begin
        exp_resp_t e;
        int n;
        reset = 1'b1; clr = 1'b0; act_valid = 1'b0; act_tag = '0; max_req = 1'b0;
        s_act_valid = 1'b0; s_act_tag = '0; s_max_req = 1'b0; s_clr = 1'b0;
        model_clear();
        m_drop = 16'd0;
        repeat (3) step();
        chk("rst_ready", 32'(act_ready), 32'd1);
        chk("rst_outs", {resp_valid, resp_hit, resp_drop, max_busy, max_valid, max_found}, 32'd0);
        chk("rst_vals", 32'(resp_idx) | 32'(resp_cnt) | 32'(drop_cnt) | 32'(max_idx) | 32'(max_tag) | 32'(max_cnt), 32'd0);
        reset = 1'b0;
        step();

        scan();
        wait_scan();
        chk("empty_found", 32'(max_found), 32'd0);

        act(16'h10); act(16'h11); act(16'h10);
        chk("t3_hit", 32'(resp_hit), 32'd1);
        chk("t3_idx", 32'(resp_idx), 32'd0);
        chk("t3_cnt", 32'(resp_cnt), 32'd2);

        do_clr();
        for (int i = 0; i < 64; i++) act(16'(16'h100 + i));
        act(16'hBEEF);
        chk("full_drop", 32'(resp_drop), 32'd1);
        chk("full_dropcnt", 32'(drop_cnt), 32'd1);
        act(16'h100);
        chk("full_keep", {31'd0, resp_hit}, 32'd1);

        repeat (4) act(16'h103);
        repeat (6) act(16'h109);
        repeat (6) act(16'h128);
        scan();
        step();
        chk("scan_ready", 32'(act_ready), 32'd0);
        chk("scan_busy", 32'(max_busy), 32'd1);
        act_valid = 1'b1; act_tag = 16'h55; max_req = 1'b1;
        step();
        act_valid = 1'b0; max_req = 1'b0;
        wait_scan();
        chk("hot_idx", 32'(max_idx), 32'd9);
        chk("hot_cnt", 32'(max_cnt), 32'd7);

`ifdef CNT_CAM_CLR_ON_MAX_EN
        scan();
        wait_scan();
        chk("clrmax_idx", 32'(max_idx), 32'd40);
        chk("clrmax_cnt", 32'(max_cnt), 32'd7);
        act(16'hCAFE);
        chk("clrmax_alloc", 32'(resp_idx), 32'd9);
`endif

        repeat (8) act(16'h102);
        chk("idx2_cnt", 32'(resp_cnt), 32'd9);
        model_act(16'h102, e);
        q_resp.push_back(e);
        push_scan();
        act_valid = 1'b1; act_tag = 16'h102; max_req = 1'b1;
        step();
        act_valid = 1'b0; max_req = 1'b0;
        wait_scan();
        chk("combo_idx", 32'(max_idx), 32'd2);
        chk("combo_cnt", 32'(max_cnt), 32'd10);

        scan();
        repeat (4) step();
        void'(q_max.pop_back());
        do_clr();
        chk("abort_ready", 32'(act_ready), 32'd1);
        chk("abort_busy", 32'(max_busy), 32'd0);
        chk("abort_keep", 32'(max_cnt), 32'd10);
        chk("abort_drop", 32'(drop_cnt), 32'(m_drop));
        repeat (25) step();
        act(16'h10);
        chk("after_clr", 32'(resp_idx), 32'd0);

        s_act_valid = 1'b1; s_act_tag = 8'h05;
        repeat (17) step();
        chk("s_sat_hit", 32'(s_resp_hit), 32'd1);
        chk("s_sat_cnt", 32'(s_resp_cnt), 32'hF);
        for (int i = 0; i < 7; i++) begin
            s_act_tag = 8'(6 + i);
            step();
        end
        s_act_tag = 8'h77;
        repeat (17) step();
        s_act_valid = 1'b0;
        chk("s_drop", 32'(s_resp_drop), 32'd1);
        chk("s_dropcnt_sat", 32'(s_drop_cnt), 32'hF);
        s_max_req = 1'b1;
        step();
        s_max_req = 1'b0;
        n = 0;
        while (!s_max_valid && n < 20) begin
            step();
            n++;
        end
        chk("s_lat", 32'(n), 32'd5);
        chk("s_max", {s_max_found, s_max_idx, s_max_tag, s_max_cnt}, {16'd0, 1'b1, 3'd0, 8'h05, 4'hF});

        repeat (3) step();
        chk("resp_drain", 32'(q_resp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
